// File: rtl/sabr_mul_pipe_if.sv
// Handshake bundle for the SABR pipelined multiplier: operand side
// (valid/ready plus operands and mode) and result side (valid/ready plus
// truncated product and overflow flag).
interface sabr_mul_pipe_if #(
  parameter int DIN0_WIDTH = 50,
  parameter int DIN1_WIDTH = 50,
  parameter int DOUT_WIDTH = 99
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, din0, din1, is_signed, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  // Multiplier side.
  modport slave (
    input  in_valid, din0, din1, is_signed, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/sabr_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier with valid/ready handshake,
// single-enable backpressure and a truncation-overflow flag.
// The product is formed at the pipeline entry and carried through
// NUM_STAGE registers so register retiming can spread the multiplier
// across the stages.
module sabr_mul_pipe #(
  parameter int DIN0_WIDTH = 50,
  parameter int DIN1_WIDTH = 50,
  parameter int DOUT_WIDTH = 99,
  parameter int NUM_STAGE  = 4
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  sabr_mul_pipe_if.slave bus
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;

  logic                  stall;
  logic                  accept;
  logic signed [PW-1:0]  a_full;
  logic signed [PW-1:0]  b_full;
  logic signed [PW-1:0]  prod;
  logic                  ovf_calc;

  logic                  valid_reg [NUM_STAGE];
  logic [DOUT_WIDTH-1:0] data_reg  [NUM_STAGE];
  logic                  ovf_reg   [NUM_STAGE];

  // The whole pipe freezes only when a finished result is not taken.
  assign stall        = valid_reg[NUM_STAGE-1] && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;

  // One-bit extension (sign or zero) and then out to the full product
  // width, so the signed multiply is exact in PW bits.
  assign a_full = {{(DIN1_WIDTH + 2){bus.is_signed & bus.din0[DIN0_WIDTH-1]}}, bus.din0};
  assign b_full = {{(DIN0_WIDTH + 2){bus.is_signed & bus.din1[DIN1_WIDTH-1]}}, bus.din1};
  assign prod   = a_full * b_full;

  generate
    if (DOUT_WIDTH >= PW) begin : g_no_ovf
      assign ovf_calc = 1'b0;
    end else begin : g_ovf
      logic [PW-DOUT_WIDTH:0] upper;
      // Bits above the result plus the result MSB: signed results must
      // have these all equal, unsigned results must have the top part zero.
      assign upper    = prod[PW-1:DOUT_WIDTH-1];
      assign ovf_calc = bus.is_signed ? !((&upper) || !(|upper))
                                      : (|upper[PW-DOUT_WIDTH:1]);
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // Entry stage: capture the product; bubbles enter with ovf cleared.
        always_ff @(posedge ap_clk) begin
          if (!ap_rst_n) begin
            valid_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
            ovf_reg[gi]   <= 1'b0;
          end else if (!stall) begin
            valid_reg[gi] <= accept;
            data_reg[gi]  <= prod[DOUT_WIDTH-1:0];
            ovf_reg[gi]   <= accept & ovf_calc;
          end
        end
      end else begin : g_next
        // Later stages: plain shift from the previous stage when not stalled.
        always_ff @(posedge ap_clk) begin
          if (!ap_rst_n) begin
            valid_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
            ovf_reg[gi]   <= 1'b0;
          end else if (!stall) begin
            valid_reg[gi] <= valid_reg[gi-1];
            data_reg[gi]  <= data_reg[gi-1];
            ovf_reg[gi]   <= ovf_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = valid_reg[NUM_STAGE-1];
  assign bus.dout      = data_reg[NUM_STAGE-1];
  assign bus.ovf       = ovf_reg[NUM_STAGE-1];

endmodule

// File: tb/tb_sabr_mul_pipe.sv
// Self-checking bench for sabr_mul_pipe: directed vectors, random streaming,
// random backpressure, reset mid-flight, and two small-width instances with
// NUM_STAGE = 1 and 7.
module tb_sabr_mul_pipe;

  localparam int NS = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  sabr_mul_pipe_if #(.DIN0_WIDTH(50), .DIN1_WIDTH(50), .DOUT_WIDTH(99)) bus_m ();
  sabr_mul_pipe_if #(.DIN0_WIDTH(8),  .DIN1_WIDTH(6),  .DOUT_WIDTH(10)) bus_a ();
  sabr_mul_pipe_if #(.DIN0_WIDTH(8),  .DIN1_WIDTH(6),  .DOUT_WIDTH(10)) bus_b ();

  sabr_mul_pipe #(.DIN0_WIDTH(50), .DIN1_WIDTH(50), .DOUT_WIDTH(99), .NUM_STAGE(NS)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_m));
  sabr_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(6), .DOUT_WIDTH(10), .NUM_STAGE(1)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_a));
  sabr_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(6), .DOUT_WIDTH(10), .NUM_STAGE(7)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_b));

  typedef struct {
    logic [127:0] d;
    bit           o;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           n_txn = 0;
  bit           lat_on = 1'b0;
  bit           stall_prev = 1'b0;
  bit           s_acc;
  bit           s_valid;
  logic [98:0]  held_dout;
  logic         held_ovf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply exactly, then
  // truncate; overflow means the truncated value no longer equals the product.
  function automatic void model(input logic [127:0] a, input logic [127:0] b, input bit sgn,
                                input int w0, input int w1, input int wo,
                                output logic [127:0] d, output bit o);
    logic signed [127:0] va, vb, p, t;
    va = a;
    vb = b;
    if (sgn) begin
      va = (va <<< (128 - w0)) >>> (128 - w0);
      vb = (vb <<< (128 - w1)) >>> (128 - w1);
    end
    p = va * vb;
    d = p & ((128'd1 << wo) - 128'd1);
    if (sgn) begin
      t = (p <<< (128 - wo)) >>> (128 - wo);
      o = (t != p);
    end else begin
      o = ((p >> wo) != 0);
    end
  endfunction

  function automatic logic [127:0] rand_op(input int w);
    logic [127:0] m, r;
    m = (128'd1 << w) - 128'd1;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       rand_op = '0;
      1:       rand_op = m;
      2:       rand_op = 128'd1 << (w - 1);
      3:       rand_op = (128'd1 << (w - 1)) - 128'd1;
      default: rand_op = r & m;
    endcase
  endfunction

  task automatic set_main_random();
    logic [127:0] t;
    t = rand_op(50);
    bus_m.din0 = t[49:0];
    t = rand_op(50);
    bus_m.din1 = t[49:0];
    bus_m.is_signed = 1'($urandom_range(0, 1));
  endtask

  // One cycle on the main instance: sample #1 after the falling edge,
  // score accepts and results, then advance to the next falling edge.
  task automatic step();
    logic [127:0] ed;
    bit           eo;
    exp_t         e;
    #1;
    check("in_ready", 128'(bus_m.in_ready), 128'(!(bus_m.out_valid && !bus_m.out_ready)));
    if (stall_prev) begin
      check("stall_valid", 128'(bus_m.out_valid), 128'd1);
      check("stall_dout", 128'(bus_m.dout), 128'(held_dout));
      check("stall_ovf", 128'(bus_m.ovf), 128'(held_ovf));
    end
    if (!bus_m.out_valid) check("ovf_idle", 128'(bus_m.ovf), 128'd0);
    s_acc   = bus_m.in_valid && bus_m.in_ready && ap_rst_n;
    s_valid = bus_m.out_valid;
    if (s_acc) begin
      model(128'(bus_m.din0), 128'(bus_m.din1), bus_m.is_signed, 50, 50, 99, ed, eo);
      e.d = ed;
      e.o = eo;
      e.acc = cyc;
      q.push_back(e);
    end
    if (bus_m.out_valid && bus_m.out_ready && ap_rst_n) begin
      if (q.size() == 0) begin
        check("spurious_out", 128'd1, 128'd0);
      end else begin
        e = q.pop_front();
        check("dout", 128'(bus_m.dout), e.d);
        check("ovf", 128'(bus_m.ovf), 128'(e.o));
        if (lat_on) check("latency", 128'(cyc - e.acc), 128'(NS));
        $display("txn %0d cyc %0d dout=%h ovf=%b", n_txn, cyc, bus_m.dout, bus_m.ovf);
        n_txn++;
      end
    end
    stall_prev = bus_m.out_valid && !bus_m.out_ready && ap_rst_n;
    held_dout  = bus_m.dout;
    held_ovf   = bus_m.ovf;
    cyc++;
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic run_directed(input string tag, input logic [127:0] a, input logic [127:0] b,
                              input bit s, input logic [127:0] exp_d, input bit exp_o);
    int lat;
    bus_m.in_valid  = 1'b1;
    bus_m.din0      = a[49:0];
    bus_m.din1      = b[49:0];
    bus_m.is_signed = s;
    bus_m.out_ready = 1'b1;
    step();
    check({tag, "_accept"}, 128'(s_acc), 128'd1);
    bus_m.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (s_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'(NS));
    check({tag, "_dout"}, 128'(held_dout), exp_d);
    check({tag, "_ovf"}, 128'(held_ovf), 128'(exp_o));
  endtask

  task automatic small_txn(input logic [127:0] a, input logic [127:0] b, input bit s,
                           input bit directed);
    logic [127:0] ed;
    bit           eo;
    int           lat_a, lat_b;
    model(a, b, s, 8, 6, 10, ed, eo);
    bus_a.din0 = a[7:0];  bus_a.din1 = b[5:0];  bus_a.is_signed = s;  bus_a.in_valid = 1'b1;
    bus_b.din0 = a[7:0];  bus_b.din1 = b[5:0];  bus_b.is_signed = s;  bus_b.in_valid = 1'b1;
    #1;
    check("sm_in_ready_a", 128'(bus_a.in_ready), 128'd1);
    check("sm_in_ready_b", 128'(bus_b.in_ready), 128'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    lat_a = 0;
    lat_b = 0;
    for (int n = 1; n <= 10; n++) begin
      #1;
      if (bus_a.out_valid && lat_a == 0) begin
        lat_a = n;
        check("sm_dout_a", 128'(bus_a.dout), ed);
        check("sm_ovf_a", 128'(bus_a.ovf), 128'(eo));
        if (directed) begin
          check("sm_255x63_dout", 128'(bus_a.dout), 128'd705);
          check("sm_255x63_ovf", 128'(bus_a.ovf), 128'd1);
        end
      end
      if (bus_b.out_valid && lat_b == 0) begin
        lat_b = n;
        check("sm_dout_b", 128'(bus_b.dout), ed);
        check("sm_ovf_b", 128'(bus_b.ovf), 128'(eo));
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    check("sm_latency_a", 128'(lat_a), 128'd1);
    check("sm_latency_b", 128'(lat_b), 128'd7);
    $display("small txn a=%0d b=%0d s=%0d lat=%0d/%0d", a, b, s, lat_a, lat_b);
  endtask

  initial begin
    logic [127:0] one, ones50, d_exp;
    int sent, bound;
    one    = 128'd1;
    ones50 = (one << 50) - one;

    bus_m.in_valid = 1'b0;  bus_m.din0 = '0;  bus_m.din1 = '0;  bus_m.is_signed = 1'b0;
    bus_m.out_ready = 1'b1;
    bus_a.in_valid = 1'b0;  bus_a.din0 = '0;  bus_a.din1 = '0;  bus_a.is_signed = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0;  bus_b.din0 = '0;  bus_b.din1 = '0;  bus_b.is_signed = 1'b0;
    bus_b.out_ready = 1'b1;

    // Reset state, with an input offered during reset.
    ap_rst_n = 1'b0;
    bus_m.in_valid = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", 128'(bus_m.out_valid), 128'd0);
    check("rst_dout", 128'(bus_m.dout), 128'd0);
    check("rst_ovf", 128'(bus_m.ovf), 128'd0);
    check("rst_out_valid_a", 128'(bus_a.out_valid), 128'd0);
    check("rst_out_valid_b", 128'(bus_b.out_valid), 128'd0);
    @(negedge ap_clk);
    bus_m.in_valid = 1'b0;
    ap_rst_n = 1'b1;
    #1;
    check("rst_in_ready", 128'(bus_m.in_ready), 128'd1);
    @(negedge ap_clk);

    // Directed vectors with no stalls.
    lat_on = 1'b1;
    d_exp = (one << 99) - (one << 51) + one;
    run_directed("umax", ones50, ones50, 1'b0, d_exp, 1'b1);
    run_directed("u3x5", 128'd3, 128'd5, 1'b0, 128'd15, 1'b0);
    d_exp = (one << 99) - 128'd7;
    run_directed("sneg1x7", ones50, 128'd7, 1'b1, d_exp, 1'b0);
    run_directed("sminxmin", one << 49, one << 49, 1'b1, one << 98, 1'b1);

    // Back-to-back streaming, one result per cycle.
    for (int i = 0; i < 100; i++) begin
      bus_m.in_valid = 1'b1;
      set_main_random();
      step();
      check("stream_accept", 128'(s_acc), 128'd1);
    end
    bus_m.in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("stream_drain", 128'(q.size()), 128'd0);

    // Random backpressure; operands held while not accepted.
    lat_on = 1'b0;
    sent = 0;
    bound = 0;
    bus_m.in_valid = 1'b1;
    set_main_random();
    while ((sent < 150 || q.size() != 0) && bound < 3000) begin
      bus_m.out_ready = ($urandom_range(0, 9) >= 3);
      step();
      if (s_acc) sent++;
      if (!(bus_m.in_valid && !s_acc)) begin
        bus_m.in_valid = (sent < 150) && ($urandom_range(0, 9) < 8);
        set_main_random();
      end
      bound++;
    end
    check("bp_timeout", 128'(bound < 3000), 128'd1);
    check("bp_count", 128'(sent), 128'd150);
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    step();

    // Reset with three transactions in flight; no result may emerge.
    for (int i = 0; i < 3; i++) begin
      bus_m.in_valid = 1'b1;
      set_main_random();
      step();
    end
    ap_rst_n = 1'b0;
    step();
    q.delete();
    ap_rst_n = 1'b1;
    bus_m.in_valid = 1'b0;
    #1;
    check("rst_mid_in_ready", 128'(bus_m.in_ready), 128'd1);
    @(negedge ap_clk);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_mid_no_out", 128'(s_valid), 128'd0);
    end

    // Small widths, NUM_STAGE = 1 and 7.
    small_txn(128'd255, 128'd63, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      small_txn(rand_op(8), rand_op(6), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
